// File: rtl/stim_gen_pkg.sv
// Shared types and constants for the stim_gen stimulus source.
package stim_pkg;

  typedef enum logic [2:0] {
    MODE_IMPULSE = 3'd0,
    MODE_STEP    = 3'd1,
    MODE_SQUARE  = 3'd2,
    MODE_RAMP    = 3'd3,
    MODE_NOISE   = 3'd4
  } stim_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [15:0] MIDSCALE  = 16'h8000;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // One Galois shift: feedback applied when the bit shifted out is set.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/stim_gen_lfsr.sv
// 16-bit Galois LFSR for the noise waveform; reloads the seed on each start.
module stim_lfsr
  import stim_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] state
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       state <= LFSR_SEED;
    else if (load)    state <= LFSR_SEED;
    else if (advance) state <= lfsr_step(state);
  end

endmodule

// File: rtl/stim_gen.sv
// Programmable waveform source (impulse/step/square/ramp) on a valid/ready stream.
// Optional noise mode compiled in with STIM_NOISE_EN.
module stim_gen
  import stim_pkg::*;
#(
  parameter int LEN_W       = 16,
  parameter int HALF_PERIOD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [LEN_W-1:0] length,
  input  logic [14:0]      amp,
  input  logic             ready,
  output logic             valid,
  output logic [15:0]      sample,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [2:0]       mode_q;
  logic [LEN_W-1:0] len_q, idx_q;
  logic [14:0]      amp_q;
  logic [15:0]      sample_q;
  logic             accept, xfer, last;
  logic [15:0]      first_sample, next_sample;

  function automatic logic [15:0] wave(input logic [2:0] m, input logic [14:0] a,
                                       input logic [LEN_W-1:0] i);
    logic [15:0]      hi, lo;
    logic [31:0]      ramp;
    logic [LEN_W-1:0] q;
    hi   = MIDSCALE + {1'b0, a};
    lo   = MIDSCALE - {1'b0, a};
    ramp = 32'(lo) + 32'(i);
    q    = i / LEN_W'(HALF_PERIOD);
    case (m)
      MODE_IMPULSE: wave = (i == '0) ? hi : MIDSCALE;
      MODE_STEP:    wave = hi;
      MODE_SQUARE:  wave = q[0] ? lo : hi;
      MODE_RAMP:    wave = (ramp > 32'(hi)) ? hi : ramp[15:0];
      default:      wave = MIDSCALE;
    endcase
  endfunction

  assign accept = (state_q == ST_IDLE) && start;
  assign xfer   = (state_q == ST_RUN) && ready;
  assign last   = (idx_q == len_q - LEN_W'(1));

`ifdef STIM_NOISE_EN
  logic [15:0] lfsr_state;

  stim_lfsr u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .advance (xfer),
    .state   (lfsr_state)
  );

  assign first_sample = (mode == MODE_NOISE) ? LFSR_SEED : wave(mode, amp, '0);
  assign next_sample  = (mode_q == MODE_NOISE) ? lfsr_step(lfsr_state)
                                               : wave(mode_q, amp_q, idx_q + LEN_W'(1));
`else
  assign first_sample = wave(mode, amp, '0);
  assign next_sample  = wave(mode_q, amp_q, idx_q + LEN_W'(1));
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (length == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (xfer && last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sample is precomputed one step ahead so nothing combinational follows ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= '0;
      len_q    <= '0;
      amp_q    <= '0;
      idx_q    <= '0;
      sample_q <= MIDSCALE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          mode_q   <= mode;
          len_q    <= length;
          amp_q    <= amp;
          idx_q    <= '0;
          sample_q <= (length == '0) ? MIDSCALE : first_sample;
        end
        ST_RUN: if (xfer) begin
          if (last) sample_q <= MIDSCALE;
          else begin
            idx_q    <= idx_q + LEN_W'(1);
            sample_q <= next_sample;
          end
        end
        default: sample_q <= MIDSCALE;
      endcase
    end
  end

  assign valid  = (state_q == ST_RUN);
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign sample = sample_q;

endmodule

// File: tb/tb_stim_gen.sv
// Scoreboard bench for stim_gen: stimulus pushes expected samples, a negedge monitor checks them.
module tb_stim_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [15:0] length = 16'd0;
  logic [14:0] amp = 15'd0;
  logic        valid, busy, done;
  logic [15:0] sample;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] sb[$];
  bit          done_due = 1'b0;
  bit          in_seq = 1'b0;

  stim_gen #(.LEN_W(16), .HALF_PERIOD(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .mode   (mode),
    .length (length),
    .amp    (amp),
    .ready  (ready),
    .valid  (valid),
    .sample (sample),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every negedge, compare presented sample against the scoreboard head.
  initial forever begin
    logic [15:0] tmp;
    @(negedge clk);
    if (reset) begin
      if (done_due) begin
        check("done_pulse", {15'd0, done}, 16'd1);
        check("busy_in_done", {15'd0, busy}, 16'd1);
        done_due = 1'b0;
      end else if (done) begin
        check("unexpected_done", {15'd0, done}, 16'd0);
      end
      if (valid) begin
        if (sb.size() == 0) check("valid_without_expect", {15'd0, valid}, 16'd0);
        else begin
          check("sample", sample, sb[0]);
          in_seq = 1'b1;
          if (ready) begin
            tmp = sb.pop_front();
            if (sb.size() == 0) begin
              done_due = 1'b1;
              in_seq   = 1'b0;
            end
          end
        end
      end else if (in_seq) begin
        check("valid_drop", {15'd0, valid}, 16'd1);
      end
    end
  end

  task automatic launch(input logic [2:0] m, input logic [15:0] len, input logic [14:0] a,
                        input bit tog);
    @(posedge clk); #1;
    mode = m; length = len; amp = a; start = 1'b1; ready = !tog;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the inputs: captured values must be unaffected.
    mode = 3'd1; amp = 15'h7FFF; length = 16'd3;
    if (len == 16'd0) done_due = 1'b1;
    else check("first_valid", {15'd0, valid}, 16'd1);
  endtask

  task automatic finish_seq(input bit tog, input bit poke);
    int c;
    for (c = 0; c < 2000 && (sb.size() != 0 || done_due); c++) begin
      @(posedge clk); #1;
      if (tog) ready = ~ready;
      start = poke && (c == 1);
      if (start) mode = 3'd3;
    end
    start = 1'b0;
    if (sb.size() != 0 || done_due)
      check("seq_timeout", 16'(sb.size()) + 16'(done_due), 16'd0);
    check("busy_after_done", {15'd0, busy}, 16'd0);
  endtask

  initial begin
    #12;
    check("rst_valid",  {15'd0, valid}, 16'd0);
    check("rst_sample", sample, 16'h8000);
    check("rst_busy",   {15'd0, busy}, 16'd0);
    check("rst_done",   {15'd0, done}, 16'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Impulse, full amplitude, full throughput
    sb.push_back(16'hFFFF);
    for (int i = 1; i < 400; i++) sb.push_back(16'h8000);
    launch(3'd0, 16'd400, 15'h7FFF, 1'b0);
    finish_seq(1'b0, 1'b0);

    // Step with ready toggling: stalls must hold the sample
    repeat (4) sb.push_back(16'hC000);
    launch(3'd1, 16'd4, 15'h4000, 1'b1);
    finish_seq(1'b1, 1'b0);

    // Square, with a start pulse mid-run that must be ignored
    repeat (8) sb.push_back(16'h9000);
    repeat (8) sb.push_back(16'h7000);
    repeat (4) sb.push_back(16'h9000);
    launch(3'd2, 16'd20, 15'h1000, 1'b0);
    finish_seq(1'b0, 1'b1);

    // Ramp saturating at M+A
    sb.push_back(16'h7FFE); sb.push_back(16'h7FFF); sb.push_back(16'h8000);
    sb.push_back(16'h8001); sb.push_back(16'h8002); sb.push_back(16'h8002);
    sb.push_back(16'h8002); sb.push_back(16'h8002);
    launch(3'd3, 16'd8, 15'd2, 1'b0);
    finish_seq(1'b0, 1'b0);

    // Zero length: done only, no samples
    launch(3'd1, 16'd0, 15'h1234, 1'b0);
    finish_seq(1'b0, 1'b0);

    // Unused mode code: constant midscale
    repeat (3) sb.push_back(16'h8000);
    launch(3'd6, 16'd3, 15'h2222, 1'b0);
    finish_seq(1'b0, 1'b0);

    // Noise (or midscale when the LFSR is compiled out)
`ifdef STIM_NOISE_EN
    sb.push_back(16'hACE1); sb.push_back(16'hE270);
`else
    sb.push_back(16'h8000); sb.push_back(16'h8000);
`endif
    launch(3'd4, 16'd2, 15'h0100, 1'b0);
    finish_seq(1'b0, 1'b0);

    // Asynchronous reset mid-run aborts with no done pulse
    sb.push_back(16'h8064);
    for (int i = 1; i < 50; i++) sb.push_back(16'h8000);
    launch(3'd0, 16'd50, 15'd100, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    sb.delete();
    in_seq = 1'b0;
    #1 reset = 1'b0;
    #1;
    check("abort_valid",  {15'd0, valid}, 16'd0);
    check("abort_sample", sample, 16'h8000);
    check("abort_busy",   {15'd0, busy}, 16'd0);
    check("abort_done",   {15'd0, done}, 16'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_after_abort", {15'd0, busy}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stim_gen.md
# stim_gen

Hardware stimulus source for the FIR datapath: on a start request it emits a programmable-length sequence of 16-bit offset-binary samples (impulse, step, square, ramp, optionally noise) through a valid/ready stream. It sits upstream of `FirLowpass` and replaces file-driven vectors for on-chip impulse and step characterisation. Sample encoding matches the filter: code 16'h8000 = 0.0; real value = code·2⁻¹⁵ − 1.

## Interface
- `LEN_W`, 16: width of the sequence-length counter.
- `HALF_PERIOD`, 8: samples per half-cycle in square mode; must be ≥1.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state.
- `start`  in  1  begin a sequence; honoured only in IDLE.
- `mode`  in  3  waveform: 0 IMPULSE, 1 STEP, 2 SQUARE, 3 RAMP, 4 NOISE; captured at start.
- `length`  in  LEN_W  number of samples to emit; captured at start.
- `amp`  in  15  amplitude about midscale; captured at start.
- `ready`  in  1  downstream accepts the sample this cycle.
- `valid`  out  1  `sample` is valid.
- `sample`  out  16  offset-binary sample.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse after the last transfer.

## Operation
- States IDLE → RUN → DONE → IDLE. Reset enters IDLE: `valid`=0, `sample`=16'h8000, `busy`=0, `done`=0, index=0.
- IDLE + `start`: latch mode/length/amp, index=0; length==0 → DONE directly (no samples); else → RUN.
- RUN: `valid`=1. Transfer when `valid && ready`; index increments on transfer. Transfer with index==length−1 → DONE.
- Stall: `valid && !ready` holds `sample` and index stable; `valid` never drops mid-sequence.
- DONE: `valid`=0, `sample`=16'h8000, `done`=1 for one cycle, then IDLE.
- `start` in RUN/DONE ignored (no queuing). Input changes after capture have no effect.
- Waveforms (M=16'h8000, A=amp, i=index): IMPULSE: i==0 → M+A, else M. STEP: M+A. SQUARE: M+A when (i/HALF_PERIOD) even, else M−A. RAMP: min(M−A+i, M+A), unsigned 16-bit, saturating at M+A. Codes 5–7: constant M.
- All sums in 16-bit unsigned; A ≤ 16'h7FFF so M±A never wraps.
- Asynchronous reset mid-sequence aborts immediately; no `done` pulse.

## Timing
- `start` sampled at edge N → `valid`=1 with index-0 sample after edge N (visible cycle N+1).
- Next sample visible the cycle after each transfer; full throughput = one sample per clock with `ready` held high.
- `done` asserts in the cycle after the final transfer; `busy` falls one cycle later; next `start` accepted in IDLE the cycle after `done`.
- length==0: `done` the cycle after start, `valid` never asserts.
- All outputs registered; no combinational path from `ready` to `sample`.

## Configuration
- `STIM_NOISE_EN` defined: mode 4 emits a 16-bit Galois LFSR, taps 16'hB400, seeded 16'hACE1 at start, advanced once per transfer; `sample` = LFSR state (first sample = 16'hACE1).
- Undefined: LFSR absent; mode 4 behaves as codes 5–7 (constant 16'h8000 for `length` samples).

## Structure
- `stim_pkg`: `stim_mode_e` enum (3-bit codes above), `state_e` (IDLE/RUN/DONE), constants MIDSCALE=16'h8000, LFSR_TAPS=16'hB400, LFSR_SEED=16'hACE1.
- Sub-module `stim_lfsr` (load, advance, 16-bit state), instantiated only under `STIM_NOISE_EN`.

## Test plan
- IMPULSE, length=400, amp=16'h7FFF, ready=1 → sample0=16'hFFFF, samples 1–399 = 16'h8000; `done` one cycle after transfer 400.
- STEP, length=4, amp=16'h4000, ready toggling 1,0,1,0… → exactly 4 transfers of 16'hC000; sample stable during stalls.
- SQUARE, HALF_PERIOD=8, amp=16'h1000, length=20 → 8×16'h9000, 8×16'h7000, 4×16'h9000.
- RAMP, amp=2, length=8 → 16'h7FFE,7FFF,8000,8001,8002,8002,8002,8002 (saturation).
- length=0 → `done` next cycle, `valid` never high; `start` during RUN ignored; reset low mid-RUN → outputs at reset values immediately, no `done`.
- NOISE with `STIM_NOISE_EN` → first two samples 16'hACE1, 16'hE270; without macro → constant 16'h8000.
